// File: rtl/spi_bitrev_pkg.sv
// Shared types and helpers for the bit-reversing SPI slave test device.
// Holds the FSM state encoding, the word-reverse function and the status counter width.
package spi_bitrev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int XFER_CNT_W = 16;
    localparam int MAX_W      = 32;
    localparam int IDX_W      = $clog2(MAX_W);

    // Reverses the low w bits of din; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] din, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[IDX_W'(i)] = din[IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall pulse detection
// on the synchronised level. Reset value is configurable so idle-high pins reset high.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // prev holds the previous synchronised sample so edges are seen one clock after settling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI mode-0 slave on the system clock: receives a DATA_W-bit word, then returns it bit-reversed
// in the same ss window. Optional status outputs are enabled by defining SPI_BITREV_STATUS_EN.
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso
`ifdef SPI_BITREV_STATUS_EN
    ,
    output logic                  xfer_done,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    state_t            state;
    logic [DATA_W-1:0] rx_reg;
    logic [DATA_W-1:0] tx_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] rx_rev;
    logic              cnt_last;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clock (clock),
        .reset (reset),
        .din   (sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clock (clock),
        .reset (reset),
        .din   (ss),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clock (clock),
        .reset (reset),
        .din   (mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_edges = ^{sck_lvl, ss_rise, ss_fall, mosi_rise, mosi_fall};

    assign rx_next  = {rx_reg[DATA_W-2:0], mosi_lvl};
    assign rx_rev   = DATA_W'(bit_rev(MAX_W'(rx_next), DATA_W));
    assign cnt_last = (bit_cnt == CNT_LAST);

    // A synchronised ss high overrides any sck edge in the same cycle and discards a partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            miso    <= 1'b1;
            rx_reg  <= '0;
            tx_reg  <= '0;
            bit_cnt <= '0;
        end else if (ss_lvl) begin
            state   <= IDLE;
            miso    <= 1'b1;
            rx_reg  <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    miso    <= 1'b1;
                    bit_cnt <= '0;
                    state   <= RX;
                end
                RX: begin
                    if (sck_rise) begin
                        rx_reg <= rx_next;
                        if (cnt_last) begin
                            tx_reg  <= rx_rev;
                            bit_cnt <= '0;
                            state   <= TX;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                TX: begin
                    if (sck_fall) begin
                        miso   <= tx_reg[DATA_W-1];
                        tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
                        if (cnt_last) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Last reply bit is held until the master's closing sck fall, then miso idles high.
                    if (sck_fall) begin
                        miso <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_BITREV_STATUS_EN
    // Counts only transfers whose TX phase completed; aborts are filtered by the ss check.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xfer_done <= 1'b0;
            xfer_cnt  <= '0;
        end else if (!ss_lvl && state == TX && sck_fall && cnt_last) begin
            xfer_done <= 1'b1;
            xfer_cnt  <= xfer_cnt + 1'b1;
        end else begin
            xfer_done <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Self-checking bench for spi_bitrev_slave: an 8-bit/2-stage and a 16-bit/3-stage instance,
// driven by a table of transfers plus directed abort, over-clock, reset and status sequences.
module tb_spi_bitrev_slave;
    import spi_bitrev_pkg::*;

    logic clock;
    logic reset;
    logic sck_pin  [2];
    logic ss_pin   [2];
    logic mosi_pin [2];
    logic miso_pin [2];

    int compared   = 0;
    int mismatched = 0;

`ifdef SPI_BITREV_STATUS_EN
    logic        xd [2];
    logic [15:0] xc [2];
    int          done_pulses = 0;
    int          long_pulses = 0;
    logic        prev_done   = 1'b0;
`endif

    spi_bitrev_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .sck   (sck_pin[0]),
        .ss    (ss_pin[0]),
        .mosi  (mosi_pin[0]),
        .miso  (miso_pin[0])
`ifdef SPI_BITREV_STATUS_EN
        ,
        .xfer_done (xd[0]),
        .xfer_cnt  (xc[0])
`endif
    );

    spi_bitrev_slave #(.DATA_W(16), .SYNC_STAGES(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .sck   (sck_pin[1]),
        .ss    (ss_pin[1]),
        .mosi  (mosi_pin[1]),
        .miso  (miso_pin[1])
`ifdef SPI_BITREV_STATUS_EN
        ,
        .xfer_done (xd[1]),
        .xfer_cnt  (xc[1])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef SPI_BITREV_STATUS_EN
    always @(negedge clock) begin
        if (xd[0]) begin
            done_pulses++;
            if (prev_done) long_pulses++;
        end
        prev_done = xd[0];
    end
`endif

    typedef struct {
        int          sel;
        int          nbits;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    // sck half period in system clocks: 4 for the 8-bit device, 3 (clock = 6*sck) for the 16-bit one
    function automatic int half_per(input int sel);
        return (sel == 0) ? 4 : 3;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One mode-0 sck cycle; miso is sampled at the end of the high phase
    task automatic sck_cycle(input int sel, input logic mo, output logic mi);
        mosi_pin[sel] = mo;
        wait_clk(half_per(sel));
        sck_pin[sel] = 1'b1;
        wait_clk(half_per(sel));
        mi = miso_pin[sel];
        sck_pin[sel] = 1'b0;
    endtask

    // Full transfer under one ss assertion; ss is left low so the caller can probe DONE
    task automatic applyStimulus(input int sel, input logic [31:0] word, input int nbits,
                                 output logic [31:0] reply);
        logic mo;
        logic mi;
        ss_pin[sel] = 1'b0;
        wait_clk(6);
        reply = '0;
        for (int i = 0; i < 2 * nbits; i++) begin
            mo = (i < nbits) ? word[nbits - 1 - i] : 1'b0;
            sck_cycle(sel, mo, mi);
            if (i >= nbits) reply = {reply[30:0], mi};
        end
        wait_clk(8);
    endtask

    task automatic end_xfer(input int sel);
        ss_pin[sel]   = 1'b1;
        mosi_pin[sel] = 1'b0;
        wait_clk(8);
    endtask

    initial begin
        logic [31:0] reply;
        logic        mi;
        int          bad;
`ifdef SPI_BITREV_STATUS_EN
        logic [15:0] base_cnt;
        logic [15:0] delta_cnt;
        int          base_pulses;
`endif

        vecs[0] = '{sel: 0, nbits: 8,  word: 32'h12,   exp: 32'h48};
        vecs[1] = '{sel: 0, nbits: 8,  word: 32'hF0,   exp: 32'h0F};
        vecs[2] = '{sel: 0, nbits: 8,  word: 32'hA0,   exp: 32'h05};
        vecs[3] = '{sel: 0, nbits: 8,  word: 32'h3C,   exp: 32'h3C};
        vecs[4] = '{sel: 0, nbits: 8,  word: 32'h80,   exp: 32'h01};
        vecs[5] = '{sel: 1, nbits: 16, word: 32'h0001, exp: 32'h8000};
        vecs[6] = '{sel: 1, nbits: 16, word: 32'hC3A5, exp: 32'hA5C3};
        vecs[7] = '{sel: 1, nbits: 16, word: 32'h1234, exp: 32'h2C48};

        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sck_pin[s]  = 1'b0;
            ss_pin[s]   = 1'b1;
            mosi_pin[s] = 1'b0;
        end
        wait_clk(3);
        checkOutput("reset_miso_a", 32'(miso_pin[0]), 32'h1);
        checkOutput("reset_miso_b", 32'(miso_pin[1]), 32'h1);
        reset = 1'b0;
        wait_clk(4);
        checkOutput("idle_miso_a", 32'(miso_pin[0]), 32'h1);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].sel, vecs[k].word, vecs[k].nbits, reply);
            checkOutput($sformatf("vec%0d_reply", k), reply, vecs[k].exp);
            checkOutput($sformatf("vec%0d_miso_done", k), 32'(miso_pin[vecs[k].sel]), 32'h1);
            end_xfer(vecs[k].sel);
            checkOutput($sformatf("vec%0d_miso_idle", k), 32'(miso_pin[vecs[k].sel]), 32'h1);
        end

        // Over-clock: extra sck cycles after DONE under the same ss
        applyStimulus(0, 32'h01, 8, reply);
        checkOutput("overclk_reply", reply, 32'h80);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            sck_cycle(0, 1'(i & 1), mi);
            if (mi !== 1'b1) bad++;
        end
        wait_clk(8);
        checkOutput("overclk_miso_not_high", 32'(bad), 32'h0);
        checkOutput("overclk_state", 32'(dut_a.state), 32'(DONE));
        end_xfer(0);

        // Abort after 4 RX bits, then a clean transfer
        ss_pin[0] = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 4; i++) sck_cycle(0, 1'b1, mi);
        end_xfer(0);
        checkOutput("abort_miso", 32'(miso_pin[0]), 32'h1);
        applyStimulus(0, 32'hF0, 8, reply);
        checkOutput("abort_then_reply", reply, 32'h0F);
        end_xfer(0);

        // Reset mid-TX after 3 reply bits of 0x48 (0,1,0): miso is 0 just before reset
        ss_pin[0] = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 11; i++) sck_cycle(0, (i < 8) ? 1'(8'h12 >> (7 - i)) : 1'b0, mi);
        checkOutput("pre_reset_miso", 32'(miso_pin[0]), 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_miso", 32'(miso_pin[0]), 32'h1);
        wait_clk(2);
        ss_pin[0] = 1'b1;
        reset = 1'b0;
        wait_clk(8);
        applyStimulus(0, 32'hA0, 8, reply);
        checkOutput("post_reset_reply", reply, 32'h05);
        end_xfer(0);

`ifdef SPI_BITREV_STATUS_EN
        base_cnt    = xc[0];
        base_pulses = done_pulses;
        applyStimulus(0, 32'h11, 8, reply);
        end_xfer(0);
        applyStimulus(0, 32'h22, 8, reply);
        end_xfer(0);
        ss_pin[0] = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 10; i++) sck_cycle(0, 1'b1, mi);
        end_xfer(0);
        applyStimulus(0, 32'h33, 8, reply);
        end_xfer(0);
        delta_cnt = xc[0] - base_cnt;
        checkOutput("status_xfer_cnt", 32'(delta_cnt), 32'h3);
        checkOutput("status_done_pulses", 32'(done_pulses - base_pulses), 32'h3);
        checkOutput("status_long_pulses", 32'(long_pulses), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
